// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: ALU ops, opcodes,
// FSM states, immediate selects and the decoded-control bundle.
package multicycle_ctrl_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;
    localparam logic [3:0] ALUOP_XOR = 4'b1101;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic [1:0] imm_sel;
        logic       is_r;
        logic       is_i;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       illegal;
    } dec_t;

    // Returns {legal, alu_op} for the shared R/I funct3 map; immediates carry no f7 except on shifts.
    function automatic logic [4:0] arith_decode(input logic [2:0] f3, input logic [6:0] f7,
                                                input logic is_reg);
        logic       f7_ok;
        logic [4:0] res;
        f7_ok = (f7 == F7_BASE) || !is_reg;
        case (f3)
            3'b000: begin
                if (is_reg && (f7 == F7_ALT)) res = {1'b1, ALUOP_SUB};
                else                          res = {f7_ok, ALUOP_ADD};
            end
            3'b111: res = {f7_ok, ALUOP_AND};
            3'b110: res = {f7_ok, ALUOP_OR};
            3'b100: res = {f7_ok, ALUOP_XOR};
            3'b010: res = {f7_ok, ALUOP_SLT};
            3'b001: res = {(f7 == F7_BASE), ALUOP_SLL};
            3'b101: begin
                if (f7 == F7_ALT) res = {1'b1, ALUOP_SRA};
                else              res = {(f7 == F7_BASE), ALUOP_SRL};
            end
            default: res = {1'b0, ALUOP_ADD};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle. The control unit is the master side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [31:0] ir;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  imm_sel;
    logic        pc_write;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        illegal_instr;
    logic [2:0]  fsm_state;

    modport master (
        input  instr, zero, mem_ready,
        output ir, alu_op, alu_src, imm_sel, pc_write, pc_src, mem_read, mem_write,
               mem_to_reg, reg_write, illegal_instr, fsm_state
    );

    modport slave (
        output instr, zero, mem_ready,
        input  ir, alu_op, alu_src, imm_sel, pc_write, pc_src, mem_read, mem_write,
               mem_to_reg, reg_write, illegal_instr, fsm_state
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields -> ALU controls, type flags, illegal.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output dec_t       dec_o
);

    logic [4:0] arith_s;

    // Unsupported encodings fall through as an ADD/immediate NOP with no type flag set.
    always_comb begin
        dec_o         = '0;
        dec_o.alu_op  = ALUOP_ADD;
        dec_o.alu_src = 1'b1;
        dec_o.imm_sel = IMM_I;
        dec_o.illegal = 1'b1;
        arith_s       = arith_decode(funct3_i, funct7_i, (opcode_i == OPC_R));
        case (opcode_i)
            OPC_R: begin
                if (arith_s[4]) begin
                    dec_o.alu_op  = arith_s[3:0];
                    dec_o.alu_src = 1'b0;
                    dec_o.is_r    = 1'b1;
                    dec_o.illegal = 1'b0;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_I: begin
                if (arith_s[4]) begin
                    dec_o.alu_op  = arith_s[3:0];
                    dec_o.is_i    = 1'b1;
                    dec_o.illegal = 1'b0;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_LW: begin
                if (funct3_i == 3'b010) begin
                    dec_o.is_lw   = 1'b1;
                    dec_o.illegal = 1'b0;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_SW: begin
                if (funct3_i == 3'b010) begin
                    dec_o.imm_sel = IMM_S;
                    dec_o.is_sw   = 1'b1;
                    dec_o.illegal = 1'b0;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_BEQ: begin
                if (funct3_i == 3'b000) begin
                    dec_o.alu_op  = ALUOP_SUB;
                    dec_o.alu_src = 1'b0;
                    dec_o.imm_sel = IMM_B;
                    dec_o.is_beq  = 1'b1;
                    dec_o.illegal = 1'b0;
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: latches the instruction in IF and sequences IF->ID->EX->MEM->WB,
// producing Moore strobes for PC, data memory and register file.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_IR    = 32'h00000013,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        branch_taken_q, branch_taken_d;
    dec_t        dec_s;
    logic        mem_op_s;

    ctrl_decode u_decode (
        .opcode_i (ir_q[6:0]),
        .funct3_i (ir_q[14:12]),
        .funct7_i (ir_q[31:25]),
        .dec_o    (dec_s)
    );

    assign mem_op_s = dec_s.is_lw | dec_s.is_sw;

    // State, instruction and branch-decision registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IF;
            ir_q           <= RESET_IR;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ir_q           <= ir_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    // Next-state logic; zero is only meaningful in EX and instr only in IF.
    always_comb begin
        state_d        = state_q;
        ir_d           = ir_q;
        branch_taken_d = branch_taken_q;
        case (state_q)
            ST_IF: begin
                ir_d    = bus.instr;
                state_d = ST_ID;
            end
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                branch_taken_d = dec_s.is_beq & bus.zero;
                state_d        = ST_MEM;
            end
            ST_MEM: begin
                if (!mem_op_s || !MEM_WAIT_EN || bus.mem_ready) state_d = ST_WB;
                else                                             state_d = ST_MEM;
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // Moore strobes and decode fan-out to the datapath.
    always_comb begin
        bus.mem_read      = (state_q == ST_MEM) & dec_s.is_lw;
        bus.mem_write     = (state_q == ST_MEM) & dec_s.is_sw;
        bus.reg_write     = (state_q == ST_WB) & (dec_s.is_r | dec_s.is_i | dec_s.is_lw)
                            & ~dec_s.illegal;
        bus.pc_write      = (state_q == ST_WB);
        bus.pc_src        = (state_q == ST_WB) & branch_taken_q;
        bus.ir            = ir_q;
        bus.alu_op        = dec_s.alu_op;
        bus.alu_src       = dec_s.alu_src;
        bus.imm_sel       = dec_s.imm_sel;
        bus.mem_to_reg    = dec_s.is_lw;
        bus.illegal_instr = dec_s.illegal;
        bus.fsm_state     = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instruction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_multicycle_ctrl;

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int NT = 20;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Supported instruction set as mask/match patterns.
    logic [31:0] t_mask  [NT] = '{
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F};
    logic [31:0] t_match [NT] = '{
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
        32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
        32'h00000013, 32'h00002013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00002003, 32'h00002023, 32'h00000063};
    logic [3:0]  t_op    [NT] = '{
        4'b0010, 4'b0110, 4'b1001, 4'b0111, 4'b1101, 4'b1000, 4'b1010, 4'b0001, 4'b0000,
        4'b0010, 4'b0111, 4'b1101, 4'b0001, 4'b0000, 4'b1001, 4'b1000, 4'b1010,
        4'b0010, 4'b0010, 4'b0110};
    int          t_kind  [NT] = '{
        K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R,
        K_I, K_I, K_I, K_I, K_I, K_I, K_I, K_I,
        K_LW, K_SW, K_BEQ};

    function automatic int lookup(input logic [31:0] w);
        for (int i = 0; i < NT; i++) begin
            if ((w & t_mask[i]) == t_match[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: step counter 0..4 through the instruction, stalling only in step 3 on a pending memory op.
    int          phase;
    logic [31:0] m_ir;
    logic        m_taken;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        int k;
        if (!rst) begin
            phase       = 0;
            m_ir        = 32'h00000013;
            m_taken     = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            k = (lookup(m_ir) < 0) ? K_ILL : t_kind[lookup(m_ir)];
            if (phase == 0) m_ir = bus.instr;
            if (phase == 2) m_taken = (k == K_BEQ) && bus.zero;
            if (!(phase == 3 && (k == K_LW || k == K_SW) && !bus.mem_ready))
                phase = (phase + 1) % 5;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int idx, k;
        logic [3:0] e_op;
        if (model_valid) begin
            idx  = lookup(m_ir);
            k    = (idx < 0) ? K_ILL : t_kind[idx];
            e_op = (idx < 0) ? 4'b0010 : t_op[idx];
            chk("state",     32'(bus.fsm_state), 32'(phase));
            chk("ir",        bus.ir, m_ir);
            chk("alu_op",    32'(bus.alu_op), 32'(e_op));
            chk("alu_src",   32'(bus.alu_src), 32'(!(k == K_R || k == K_BEQ)));
            chk("imm_sel",   32'(bus.imm_sel), (k == K_SW) ? 32'd1 : ((k == K_BEQ) ? 32'd2 : 32'd0));
            chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(k == K_LW));
            chk("illegal",   32'(bus.illegal_instr), 32'(k == K_ILL));
            chk("mem_read",  32'(bus.mem_read), 32'(phase == 3 && k == K_LW));
            chk("mem_write", 32'(bus.mem_write), 32'(phase == 3 && k == K_SW));
            chk("reg_write", 32'(bus.reg_write), 32'(phase == 4 && (k == K_R || k == K_I || k == K_LW)));
            chk("pc_write",  32'(bus.pc_write), 32'(phase == 4));
            chk("pc_src",    32'(bus.pc_src), 32'(phase == 4 && m_taken));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] obs_alu;
    logic       obs_src, obs_rw, obs_pcw, obs_pcsrc, obs_m2r, obs_ill;
    logic [2:0] obs_wb_state;
    int         obs_mem;

    // Runs one instruction from IF; zero toggled to show it is only sampled in EX.
    task automatic run_instr(input logic [31:0] ins, input logic z_ex, input logic z_mem,
                             input int stall);
        int n, iter;
        bus.instr = ins;
        bus.zero  = z_mem;
        cyc(1);
        bus.instr = ~ins;
        cyc(1);
        bus.zero  = z_ex;
        obs_alu   = bus.alu_op;
        obs_src   = bus.alu_src;
        cyc(1);
        bus.zero      = z_mem;
        bus.mem_ready = (stall == 0);
        n       = stall;
        obs_mem = 0;
        iter    = 0;
        while (bus.fsm_state == 3'd3 && iter < 20) begin
            if (bus.mem_read || bus.mem_write) obs_mem++;
            iter++;
            cyc(1);
            n--;
            bus.mem_ready = (n <= 0);
        end
        obs_wb_state = bus.fsm_state;
        obs_rw       = bus.reg_write;
        obs_pcw      = bus.pc_write;
        obs_pcsrc    = bus.pc_src;
        obs_m2r      = bus.mem_to_reg;
        obs_ill      = bus.illegal_instr;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        cyc(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.instr     = 32'h00000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        cyc(2);
        rst = 1'b1;
        chk("rst_state",    32'(bus.fsm_state), 32'd0);
        chk("rst_alu_op",   32'(bus.alu_op), 32'h2);
        chk("rst_alu_src",  32'(bus.alu_src), 32'd1);
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);

        // All-zero word is illegal: only pc_write in WB, ALU stays on ADD.
        run_instr(32'h00000000, 1'b0, 1'b0, 0);
        chk("nop_ex_alu",   32'(obs_alu), 32'h2);
        chk("nop_mem",      32'(obs_mem), 32'd0);
        chk("nop_wb_state", 32'(obs_wb_state), 32'd4);
        chk("nop_rw",       32'(obs_rw), 32'd0);
        chk("nop_pcw",      32'(obs_pcw), 32'd1);

        run_instr(32'h002081B3, 1'b0, 1'b0, 0);
        chk("add_alu",   32'(obs_alu), 32'h2);
        chk("add_src",   32'(obs_src), 32'd0);
        chk("add_rw",    32'(obs_rw), 32'd1);
        chk("add_pcw",   32'(obs_pcw), 32'd1);
        chk("add_pcsrc", 32'(obs_pcsrc), 32'd0);

        run_instr(32'h00208463, 1'b1, 1'b0, 0);
        chk("beq_t_alu",   32'(obs_alu), 32'h6);
        chk("beq_t_pcsrc", 32'(obs_pcsrc), 32'd1);
        chk("beq_t_rw",    32'(obs_rw), 32'd0);

        run_instr(32'h00208463, 1'b0, 1'b1, 0);
        chk("beq_nt_pcsrc", 32'(obs_pcsrc), 32'd0);

        run_instr(32'h0000A183, 1'b0, 1'b0, 3);
        chk("lw_mem_cycles", 32'(obs_mem), 32'd4);
        chk("lw_rw",         32'(obs_rw), 32'd1);
        chk("lw_m2r",        32'(obs_m2r), 32'd1);

        run_instr(32'h4020D193, 1'b0, 1'b0, 0);
        chk("srai_alu", 32'(obs_alu), 32'hA);
        chk("srai_src", 32'(obs_src), 32'd1);

        run_instr(32'h40209193, 1'b0, 1'b0, 0);
        chk("slli_bad_ill", 32'(obs_ill), 32'd1);
        chk("slli_bad_rw",  32'(obs_rw), 32'd0);
        chk("slli_bad_pcw", 32'(obs_pcw), 32'd1);

        // SW aborted by reset while stalled in MEM.
        bus.instr     = 32'h0020A023;
        bus.mem_ready = 1'b0;
        cyc(3);
        chk("sw_mem_state", 32'(bus.fsm_state), 32'd3);
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b0;
        cyc(1);
        chk("sw_abort_state", 32'(bus.fsm_state), 32'd0);
        chk("sw_abort_mw",    32'(bus.mem_write), 32'd0);
        chk("sw_abort_pcw",   32'(bus.pc_write), 32'd0);
        chk("sw_abort_ir",    bus.ir, 32'h00000013);
        rst           = 1'b1;
        bus.mem_ready = 1'b1;

        run_instr(32'h0020A023, 1'b0, 1'b0, 1);
        chk("sw_mem_cycles", 32'(obs_mem), 32'd2);
        chk("sw_rw",         32'(obs_rw), 32'd0);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
